// File: rtl/seg7_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg7_mux
// Description : Time-multiplexed driver for a common-anode-style array of
//               DIGITS seven-segment digits. Each digit is lit for DWELL
//               cycles, separated by BLANK_CYC all-off cycles. New values are
//               double-buffered and only committed at the start of a frame.
//               Optional leading-zero blanking is built when the macro
//               SEG7_MUX_LZB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_mux #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DWELL     = 1000,
    parameter int unsigned BLANK_CYC = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*DIGITS-1:0]   iv_value,
    input  logic [DIGITS-1:0]     iv_dp,
    input  logic                  i_load,
    output logic [DIGITS-1:0]     ov_an,
    output logic [6:0]            ov_seg,
    output logic                  o_dp,
    output logic                  o_frame
);

    // Digit index and phase counter widths; both are kept at least 1 bit wide
    localparam int unsigned c_idx_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned c_max_cyc = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int unsigned c_cnt_w   = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;

    localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL - 1);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(DIGITS - 1);

    localparam logic [0:0] c_blank = 1'b0;
    localparam logic [0:0] c_show  = 1'b1;

    // Seven-segment decode, active-high {g,f,e,d,c,b,a}
    function automatic logic [6:0] f_seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0111111;
            4'h1:    seg = 7'b0000110;
            4'h2:    seg = 7'b1011011;
            4'h3:    seg = 7'b1001111;
            4'h4:    seg = 7'b1100110;
            4'h5:    seg = 7'b1101101;
            4'h6:    seg = 7'b1111101;
            4'h7:    seg = 7'b0000111;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1101111;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b1111100;
            4'hC:    seg = 7'b0111001;
            4'hD:    seg = 7'b1011110;
            4'hE:    seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
        return seg;
    endfunction

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_idx_w-1:0]  w_idx_nxt;
    logic                w_enter_show;
    logic                w_frame_start;

    logic [4*DIGITS-1:0] r_disp_val;
    logic [DIGITS-1:0]   r_disp_dp;
    logic [4*DIGITS-1:0] r_pend_val;
    logic [DIGITS-1:0]   r_pend_dp;
    logic                r_pend_flag;
    logic [4*DIGITS-1:0] w_disp_val_nxt;
    logic [DIGITS-1:0]   w_disp_dp_nxt;
    logic [4*DIGITS-1:0] w_pend_val_nxt;
    logic [DIGITS-1:0]   w_pend_dp_nxt;
    logic                w_pend_flag_nxt;

    logic [DIGITS-1:0]   w_lz;
    logic [DIGITS-1:0]   w_an_nxt;
    logic [6:0]          w_seg_nxt;
    logic                w_dp_nxt;

    // State register: phase FSM, dwell counter, digit index and data buffers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= c_blank;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_disp_val  <= '0;
            r_disp_dp   <= '0;
            r_pend_val  <= '0;
            r_pend_dp   <= '0;
            r_pend_flag <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_disp_val  <= w_disp_val_nxt;
            r_disp_dp   <= w_disp_dp_nxt;
            r_pend_val  <= w_pend_val_nxt;
            r_pend_dp   <= w_pend_dp_nxt;
            r_pend_flag <= w_pend_flag_nxt;
        end
    end

    // Next-state logic: BLANK for BLANK_CYC cycles, SHOW for DWELL cycles
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + 1'b1;
        w_idx_nxt    = r_idx;
        w_enter_show = 1'b0;
        case (r_state)
            c_blank: begin
                // With no blanking configured, BLANK only exists right after reset
                if ((BLANK_CYC == 0) || (r_cnt == c_blank_last)) begin
                    w_state_nxt  = c_show;
                    w_cnt_nxt    = '0;
                    w_enter_show = 1'b1;
                end
            end
            c_show: begin
                if (r_cnt == c_dwell_last) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = (r_idx == c_idx_last) ? '0 : (r_idx + 1'b1);
                    if (BLANK_CYC == 0) begin
                        w_state_nxt  = c_show;
                        w_enter_show = 1'b1;
                    end else begin
                        w_state_nxt  = c_blank;
                    end
                end
            end
            default: begin
                w_state_nxt = c_blank;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_frame_start = w_enter_show && (w_idx_nxt == '0);

    // Double buffer: loads land in pending, commit only at frame start
    always_comb begin
        w_disp_val_nxt  = r_disp_val;
        w_disp_dp_nxt   = r_disp_dp;
        w_pend_val_nxt  = r_pend_val;
        w_pend_dp_nxt   = r_pend_dp;
        w_pend_flag_nxt = r_pend_flag;
        if (w_frame_start) begin
            if (r_pend_flag) begin
                w_disp_val_nxt = r_pend_val;
                w_disp_dp_nxt  = r_pend_dp;
            end
            w_pend_flag_nxt = 1'b0;
        end
        // A load on the commit edge is applied after the commit, so it survives
        if (i_load) begin
            w_pend_val_nxt  = iv_value;
            w_pend_dp_nxt   = iv_dp;
            w_pend_flag_nxt = 1'b1;
        end
    end

`ifdef SEG7_MUX_LZB_EN
    logic w_lz_run;

    // Leading-zero mask: digit k>0 blanks when it and every higher nibble are zero
    always_comb begin
        w_lz     = '0;
        w_lz_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_lz_run = w_lz_run & (w_disp_val_nxt[4*k +: 4] == 4'h0);
            w_lz[k]  = w_lz_run;
        end
    end
`else
    assign w_lz = '0;
`endif

    // Output logic: drive values for the phase being entered so they register together
    always_comb begin
        w_an_nxt  = '0;
        w_seg_nxt = '0;
        w_dp_nxt  = 1'b0;
        if (w_state_nxt == c_show) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (w_idx_nxt == c_idx_w'(k)) begin
                    w_an_nxt[k] = 1'b1;
                    w_seg_nxt   = f_seg7(w_disp_val_nxt[4*k +: 4]) & {7{~w_lz[k]}};
                    w_dp_nxt    = w_disp_dp_nxt[k];
                end
            end
        end
    end

    // Output register: anode, segments and dp all change on the same edge
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ov_an   <= '0;
            ov_seg  <= '0;
            o_dp    <= 1'b0;
            o_frame <= 1'b0;
        end else begin
            ov_an   <= w_an_nxt;
            ov_seg  <= w_seg_nxt;
            o_dp    <= w_dp_nxt;
            o_frame <= w_frame_start;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_mux
// Description : Self-checking bench for seg7_mux. Two instances share the
//               stimulus: DIGITS=4/DWELL=4 with BLANK_CYC=2 and BLANK_CYC=0.
//               Expected outputs come from a frame-position model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_mux;

    localparam int DW = 4;
`ifdef SEG7_MUX_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dpin;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b, fr_a, fr_b;

    always #5 clk = ~clk;

    seg7_mux #(.DIGITS(4), .DWELL(DW), .BLANK_CYC(2)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .iv_value(value), .iv_dp(dpin), .i_load(load),
        .ov_an(an_a), .ov_seg(seg_a), .o_dp(dp_a), .o_frame(fr_a)
    );

    seg7_mux #(.DIGITS(4), .DWELL(DW), .BLANK_CYC(0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .iv_value(value), .iv_dp(dpin), .i_load(load),
        .ov_an(an_b), .ov_seg(seg_b), .o_dp(dp_b), .o_frame(fr_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (frame position arithmetic) ----------
    int          mk    [2];
    logic [15:0] mdisp [2];
    logic [15:0] mpend [2];
    logic [3:0]  mdpd  [2];
    logic [3:0]  mdpp  [2];
    bit          mflag [2];
    logic [3:0]  e_an  [2];
    logic [6:0]  e_seg [2];
    logic        e_dp  [2];
    logic        e_fr  [2];

    function automatic int blank_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] d, input int slot);
        logic [15:0] sh;
        sh = d >> (4 * slot);
        if (LZB && slot > 0 && sh == 16'h0) return 7'b0;
        return SEG_TAB[sh[3:0]];
    endfunction

    // Position within the frame after edge number k (k>=1) since release
    function automatic int frame_pos(input int i, input int k);
        int b;
        b = blank_of(i);
        return (k - ((b == 0) ? 1 : 0)) % (4 * (DW + b));
    endfunction

    function automatic bit next_is_frame(input int i);
        return frame_pos(i, mk[i] + 1) == blank_of(i);
    endfunction

    task automatic model_edge(input int i);
        int b, q, slot, r;
        bit frame;
        if (!rst_n) begin
            mk[i] = 0; mdisp[i] = '0; mpend[i] = '0; mdpd[i] = '0; mdpp[i] = '0; mflag[i] = 1'b0;
            e_an[i] = '0; e_seg[i] = '0; e_dp[i] = 1'b0; e_fr[i] = 1'b0;
            return;
        end
        b = blank_of(i);
        mk[i]++;
        q = frame_pos(i, mk[i]);
        slot = q / (DW + b);
        r = q % (DW + b);
        frame = (q == b);
        if (frame && mflag[i]) begin
            mdisp[i] = mpend[i];
            mdpd[i]  = mdpp[i];
            mflag[i] = 1'b0;
        end
        if (load) begin
            mpend[i] = value;
            mdpp[i]  = dpin;
            mflag[i] = 1'b1;
        end
        if (r >= b) begin
            e_an[i]  = 4'(1 << slot);
            e_seg[i] = exp_seg(mdisp[i], slot);
            e_dp[i]  = mdpd[i][slot];
        end else begin
            e_an[i] = '0; e_seg[i] = '0; e_dp[i] = 1'b0;
        end
        e_fr[i] = frame;
    endtask

    int cyc = 0;
    int last_fr_b = -1;

    // One clock: advance the model, then compare both instances away from the edge
    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        cyc++;
        check("a_outs", {19'b0, an_a, seg_a, dp_a, fr_a}, {19'b0, e_an[0], e_seg[0], e_dp[0], e_fr[0]});
        check("b_outs", {19'b0, an_b, seg_b, dp_b, fr_b}, {19'b0, e_an[1], e_seg[1], e_dp[1], e_fr[1]});
        if (mk[1] >= 1) check("b_an_nonzero", {31'b0, an_b != 4'b0}, 32'd1);
        if (mk[1] == 0) begin
            last_fr_b = -1;
        end else if (fr_b) begin
            if (last_fr_b >= 0) check("b_frame_period", cyc - last_fr_b, 32'd16);
            last_fr_b = cyc;
        end
    endtask

    task automatic wait_frame();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step();
            if (fr_a) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_timeout", {31'b0, ok}, 32'd1);
    endtask

    task automatic safe_load(input logic [15:0] v, input logic [3:0] d);
        for (int n = 0; n < 4 && next_is_frame(0); n++) step();
        value = v; dpin = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    logic [27:0] cap_seg;
    logic [3:0]  cap_dp;

    // Record the segments/dp of each digit over one frame starting at the current cycle
    task automatic capture_frame();
        cap_seg = '1;
        cap_dp  = '1;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) step();
            for (int k = 0; k < 4; k++) begin
                if (an_a == 4'(1 << k)) begin
                    cap_seg[7*k +: 7] = seg_a;
                    cap_dp[k] = dp_a;
                end
            end
        end
    endtask

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [27:0] seg;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  edp;
    } vec_t;

    vec_t tv [6];

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n, nb, bad;
        logic [15:0] v1234;

        tv[0] = '{16'h1234, 4'b0000, {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}, 4'b0000};
        tv[1] = '{16'hABCD, 4'b1010, {7'b1110111, 7'b1111100, 7'b0111001, 7'b1011110}, 4'b1010};
        tv[4] = '{16'h8000, 4'b1000, {7'b1111111, 7'b0111111, 7'b0111111, 7'b0111111}, 4'b1000};
`ifdef SEG7_MUX_LZB_EN
        tv[2] = '{16'h0050, 4'b0100, {7'b0000000, 7'b0000000, 7'b1101101, 7'b0111111}, 4'b0100};
        tv[3] = '{16'h0000, 4'b0001, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}, 4'b0001};
        tv[5] = '{16'h0907, 4'b0000, {7'b0000000, 7'b1101111, 7'b0111111, 7'b0000111}, 4'b0000};
`else
        tv[2] = '{16'h0050, 4'b0100, {7'b0111111, 7'b0111111, 7'b1101101, 7'b0111111}, 4'b0100};
        tv[3] = '{16'h0000, 4'b0001, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}, 4'b0001};
        tv[5] = '{16'h0907, 4'b0000, {7'b0111111, 7'b1101111, 7'b0111111, 7'b0000111}, 4'b0000};
`endif

        // Reset with a load request that must be ignored
        rst_n = 1'b0; load = 1'b1; value = 16'hFFFF; dpin = 4'hF;
        repeat (3) step();
        check("rst_an", {28'b0, an_a}, 32'd0);
        check("rst_seg", {25'b0, seg_a}, 32'd0);
        check("rst_dp", {31'b0, dp_a}, 32'd0);
        check("rst_frame", {31'b0, fr_a}, 32'd0);

        // Release: digit 0 first appears BLANK_CYC cycles later (1 edge when no blanking)
        load = 1'b0; rst_n = 1'b1;
        n = 0; nb = 0;
        while (an_a == 4'b0 && n < 50) begin
            step();
            n++;
            if (nb == 0 && an_b != 4'b0) nb = n;
        end
        check("release_latency_a", n, 32'd2);
        check("release_latency_b", nb, 32'd1);
        check("release_frame_a", {31'b0, fr_a}, 32'd1);

        // Table-driven: load, then check the next full frame digit by digit
        for (int v = 0; v < 6; v++) begin
            safe_load(tv[v].val, tv[v].dp);
            wait_frame();
            capture_frame();
            for (int k = 0; k < 4; k++)
                check($sformatf("vec%0d_seg%0d", v, k), {25'b0, cap_seg[7*k +: 7]}, {25'b0, tv[v].seg[7*k +: 7]});
            check($sformatf("vec%0d_dp", v), {28'b0, cap_dp}, {28'b0, tv[v].edp});
        end

        // Mid-frame load is held back until the next frame
        v1234 = 16'h1234;
        safe_load(v1234, 4'b0000);
        wait_frame();
        repeat (8) step();
        safe_load(16'hABCD, 4'b0000);
        bad = 0; n = 0;
        while (!fr_a && n < 100) begin
            for (int k = 0; k < 4; k++)
                if (an_a == 4'(1 << k) && seg_a != SEG_TAB[(v1234 >> (4*k)) & 16'hF]) bad++;
            step();
            n++;
        end
        check("midload_changes", bad, 32'd0);
        check("midload_new_d0", {25'b0, seg_a}, {25'b0, 7'b1011110});

        // Load exactly on the commit edge: old pending commits, new one waits a frame
        safe_load(16'h1111, 4'b0000);
        for (int m = 0; m < 30 && !next_is_frame(0); m++) step();
        value = 16'h2222; load = 1'b1;
        step();
        load = 1'b0;
        check("commit_edge_frame", {31'b0, fr_a}, 32'd1);
        check("commit_edge_first", {25'b0, seg_a}, {25'b0, 7'b0000110});
        wait_frame();
        check("commit_edge_second", {25'b0, seg_a}, {25'b0, 7'b1011011});

        // One-cycle reset while digit 2 is lit
        n = 0;
        while (an_a != 4'b0100 && n < 100) begin
            step();
            n++;
        end
        check("reach_digit2", {28'b0, an_a}, 32'h4);
        rst_n = 1'b0; load = 1'b1; value = 16'h9999;
        step();
        load = 1'b0; rst_n = 1'b1;
        check("midrst_zero", {19'b0, an_a, seg_a, dp_a, fr_a}, 32'd0);
        n = 0;
        while (an_a == 4'b0 && n < 50) begin
            step();
            n++;
        end
        check("midrst_latency", n, 32'd2);
        check("midrst_an", {28'b0, an_a}, 32'd1);
        check("midrst_seg", {25'b0, seg_a}, {25'b0, 7'b0111111});

        // Random traffic against the model, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dpin  = 4'($urandom);
            step();
        end
        rst_n = 1'b1; load = 1'b0;
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
